// File: rtl/add_sub_issue.sv
// Issue/retire stage wrapped around the combinational add/sub unit.
// Registers operands, captures result/overflow, and keeps overflow status.
module add_sub_issue #(
  parameter int DATA_WIDTH = 16,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_a,
  input  logic [DATA_WIDTH-1:0] in_b,
  input  logic [3:0]            in_func,
  input  logic                  in_chain,
  output logic [DATA_WIDTH-1:0] alu_a,
  output logic [DATA_WIDTH-1:0] alu_b,
  output logic [3:0]            alu_func,
  input  logic [DATA_WIDTH-1:0] alu_c,
  input  logic                  alu_ovf,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_c,
  output logic                  out_ovf,
  output logic                  sticky_ovf,
  output logic [CNT_WIDTH-1:0]  ovf_count,
  input  logic                  clear_status
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_DONE
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [DATA_WIDTH-1:0] r_a;
  logic [DATA_WIDTH-1:0] r_b;
  logic [3:0]            r_func;
  logic [DATA_WIDTH-1:0] r_c;
  logic                  r_ovf;
  logic                  r_sticky;
  logic [CNT_WIDTH-1:0]  r_cnt;
  logic                  w_accept;
  logic                  w_capture;

  assign in_ready  = (r_state == S_IDLE) |
                     ((r_state == S_DONE) & out_ready);
  assign w_accept  = in_valid & in_ready;
  assign w_capture = (r_state == S_EXEC);

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (in_valid) w_next = S_EXEC;
      S_EXEC: w_next = S_DONE;
      S_DONE: begin
        if (out_ready)
          w_next = in_valid ? S_EXEC : S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // r_c doubles as the chain register: it always holds the last capture
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_func   <= '0;
      r_c      <= '0;
      r_ovf    <= 1'b0;
      r_sticky <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_a    <= in_chain ? r_c : in_a;
        r_b    <= in_b;
        r_func <= in_func;
      end
      if (w_capture) begin
        r_c   <= alu_c;
        r_ovf <= alu_ovf;
      end
      if (w_capture && alu_ovf) begin
        r_sticky <= 1'b1;
        if (clear_status)
          r_cnt <= CNT_WIDTH'(1);
        else if (!(&r_cnt))
          r_cnt <= r_cnt + CNT_WIDTH'(1);
      end else if (clear_status) begin
        r_sticky <= 1'b0;
        r_cnt    <= '0;
      end
    end
  end

  assign alu_a      = r_a;
  assign alu_b      = r_b;
  assign alu_func   = r_func;
  assign out_valid  = (r_state == S_DONE);
  assign out_c      = r_c;
  assign out_ovf    = r_ovf;
  assign sticky_ovf = r_sticky;
  assign ovf_count  = r_cnt;

endmodule

// File: tb/tb_add_sub_issue.sv
// Directed bench for add_sub_issue with a behavioural add/sub unit.
// Each task drives one scenario and checks results inline.
module tb_add_sub_issue;

  localparam int DW = 16;
  localparam int CW = 8;
  localparam logic [3:0] FUNC_ADD = 4'd1;
  localparam logic [3:0] FUNC_SUB = 4'd2;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_a;
  logic [DW-1:0] in_b;
  logic [3:0]    in_func;
  logic          in_chain;
  logic [DW-1:0] alu_a;
  logic [DW-1:0] alu_b;
  logic [3:0]    alu_func;
  logic [DW-1:0] alu_c;
  logic          alu_ovf;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_c;
  logic          out_ovf;
  logic          sticky_ovf;
  logic [CW-1:0] ovf_count;
  logic          clear_status;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  add_sub_issue #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_func(in_func), .in_chain(in_chain),
    .alu_a(alu_a), .alu_b(alu_b), .alu_func(alu_func),
    .alu_c(alu_c), .alu_ovf(alu_ovf),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_c(out_c), .out_ovf(out_ovf),
    .sticky_ovf(sticky_ovf), .ovf_count(ovf_count),
    .clear_status(clear_status)
  );

  // stand-in for the downstream add/sub unit
  always_comb begin
    alu_c   = '0;
    alu_ovf = 1'b0;
    case (alu_func)
      FUNC_ADD: begin
        alu_c   = alu_a + alu_b;
        alu_ovf = (alu_a[DW-1] == alu_b[DW-1]) && (alu_c[DW-1] != alu_a[DW-1]);
      end
      FUNC_SUB: begin
        alu_c   = alu_a - alu_b;
        alu_ovf = (alu_a[DW-1] != alu_b[DW-1]) && (alu_c[DW-1] != alu_a[DW-1]);
      end
      default: ;
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // present a request for exactly one edge (caller ensures in_ready)
  task automatic accept(input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input logic [3:0] f, input logic ch);
    in_valid = 1'b1; in_a = a; in_b = b; in_func = f; in_chain = ch;
    tick();
    in_valid = 1'b0; in_chain = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready got %b exp 1", in_ready); end
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid got %b exp 0", out_valid); end
    n_vec++; if (alu_a !== 16'h0 || alu_b !== 16'h0 || alu_func !== 4'h0) begin n_err++; $display("FAIL rst_alu got %h %h %h exp 0 0 0", alu_a, alu_b, alu_func); end
    n_vec++; if (out_c !== 16'h0 || out_ovf !== 1'b0) begin n_err++; $display("FAIL rst_out got %h %b exp 0 0", out_c, out_ovf); end
    n_vec++; if (sticky_ovf !== 1'b0 || ovf_count !== 8'h0) begin n_err++; $display("FAIL rst_status got %b %h exp 0 00", sticky_ovf, ovf_count); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_basic_add();
    accept(16'h0003, 16'h0004, FUNC_ADD, 1'b0);
    n_vec++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin n_err++; $display("FAIL exec_flags got v=%b r=%b exp 0 0", out_valid, in_ready); end
    n_vec++; if (alu_a !== 16'h0003 || alu_b !== 16'h0004 || alu_func !== FUNC_ADD) begin n_err++; $display("FAIL exec_ops got %h %h %h exp 0003 0004 1", alu_a, alu_b, alu_func); end
    tick();
    n_vec++; if (out_valid !== 1'b1 || out_c !== 16'h0007 || out_ovf !== 1'b0) begin n_err++; $display("FAIL add_result got v=%b c=%h o=%b exp 1 0007 0", out_valid, out_c, out_ovf); end
    tick();
    n_vec++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_err++; $display("FAIL back_idle got v=%b r=%b exp 0 1", out_valid, in_ready); end
  endtask

  task automatic test_overflow();
    accept(16'h7FFF, 16'h0001, FUNC_ADD, 1'b0);
    tick();
    n_vec++; if (out_c !== 16'h8000 || out_ovf !== 1'b1) begin n_err++; $display("FAIL add_ovf got %h %b exp 8000 1", out_c, out_ovf); end
    n_vec++; if (sticky_ovf !== 1'b1 || ovf_count !== 8'd1) begin n_err++; $display("FAIL status1 got %b %h exp 1 01", sticky_ovf, ovf_count); end
    tick();
    accept(16'h8000, 16'h0001, FUNC_SUB, 1'b0);
    tick();
    n_vec++; if (out_c !== 16'h7FFF || out_ovf !== 1'b1 || ovf_count !== 8'd2) begin n_err++; $display("FAIL sub_ovf got %h %b %h exp 7fff 1 02", out_c, out_ovf, ovf_count); end
    tick();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    accept(16'h0001, 16'h0002, FUNC_ADD, 1'b0);
    tick();
    in_valid = 1'b1; in_a = 16'h0100; in_b = 16'h0200; in_func = FUNC_ADD;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_vec++; if (out_valid !== 1'b1 || out_c !== 16'h0003 || in_ready !== 1'b0 || alu_a !== 16'h0001) begin n_err++; $display("FAIL bp_hold%0d got v=%b c=%h r=%b a=%h exp 1 0003 0 0001", i, out_valid, out_c, in_ready, alu_a); end
    end
    out_ready = 1'b1;
    #1;
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_ready_comb got %b exp 1", in_ready); end
    tick();
    in_valid = 1'b0;
    n_vec++; if (out_valid !== 1'b0 || alu_a !== 16'h0100 || alu_b !== 16'h0200) begin n_err++; $display("FAIL bp_b2b_exec got v=%b a=%h b=%h exp 0 0100 0200", out_valid, alu_a, alu_b); end
    tick();
    n_vec++; if (out_valid !== 1'b1 || out_c !== 16'h0300) begin n_err++; $display("FAIL bp_b2b_result got v=%b c=%h exp 1 0300", out_valid, out_c); end
    tick();
  endtask

  task automatic test_chain();
    accept(16'h0010, 16'h0005, FUNC_ADD, 1'b0);
    tick();
    n_vec++; if (out_c !== 16'h0015) begin n_err++; $display("FAIL chain_seed got %h exp 0015", out_c); end
    accept(16'hFFFF, 16'h0001, FUNC_SUB, 1'b1);
    n_vec++; if (alu_a !== 16'h0015) begin n_err++; $display("FAIL chain_opa got %h exp 0015", alu_a); end
    tick();
    n_vec++; if (out_c !== 16'h0014 || out_ovf !== 1'b0) begin n_err++; $display("FAIL chain_result got %h %b exp 0014 0", out_c, out_ovf); end
    tick();
    accept(16'h0005, 16'h0006, 4'hF, 1'b0);
    tick();
    n_vec++; if (out_valid !== 1'b1 || out_c !== 16'h0000 || out_ovf !== 1'b0 || alu_func !== 4'hF) begin n_err++; $display("FAIL other_func got v=%b c=%h o=%b f=%h exp 1 0000 0 f", out_valid, out_c, out_ovf, alu_func); end
    tick();
  endtask

  task automatic test_saturation();
    clear_status = 1'b1;
    tick();
    clear_status = 1'b0;
    n_vec++; if (sticky_ovf !== 1'b0 || ovf_count !== 8'h00) begin n_err++; $display("FAIL clear got %b %h exp 0 00", sticky_ovf, ovf_count); end
    for (int i = 1; i <= 260; i++) begin
      accept(16'h7FFF, 16'h0001, FUNC_ADD, 1'b0);
      tick();
      if (i == 100) begin
        n_vec++; if (ovf_count !== 8'd100) begin n_err++; $display("FAIL cnt100 got %h exp 64", ovf_count); end
      end
      if (i == 255) begin
        n_vec++; if (ovf_count !== 8'hFF) begin n_err++; $display("FAIL cnt255 got %h exp ff", ovf_count); end
      end
    end
    n_vec++; if (ovf_count !== 8'hFF || sticky_ovf !== 1'b1) begin n_err++; $display("FAIL saturate got %h %b exp ff 1", ovf_count, sticky_ovf); end
    accept(16'h7FFF, 16'h0001, FUNC_ADD, 1'b0);
    clear_status = 1'b1;
    tick();
    clear_status = 1'b0;
    n_vec++; if (ovf_count !== 8'd1 || sticky_ovf !== 1'b1) begin n_err++; $display("FAIL clear_vs_capture got %h %b exp 01 1", ovf_count, sticky_ovf); end
    tick();
  endtask

  task automatic test_reset_mid();
    accept(16'h0001, 16'h0001, FUNC_ADD, 1'b0);
    reset = 1'b1;
    #1;
    n_vec++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || alu_a !== 16'h0 || alu_func !== 4'h0) begin n_err++; $display("FAIL midrst_ctl got v=%b r=%b a=%h f=%h exp 0 1 0000 0", out_valid, in_ready, alu_a, alu_func); end
    n_vec++; if (out_c !== 16'h0 || sticky_ovf !== 1'b0 || ovf_count !== 8'h0) begin n_err++; $display("FAIL midrst_data got c=%h s=%b n=%h exp 0000 0 00", out_c, sticky_ovf, ovf_count); end
    tick();
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL midrst_nopulse got %b exp 0", out_valid); end
    reset = 1'b0;
    tick();
    accept(16'h0002, 16'h0003, FUNC_ADD, 1'b0);
    tick();
    n_vec++; if (out_valid !== 1'b1 || out_c !== 16'h0005) begin n_err++; $display("FAIL post_rst got v=%b c=%h exp 1 0005", out_valid, out_c); end
    tick();
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0;
    in_func = '0; in_chain = 1'b0; out_ready = 1'b1; clear_status = 1'b0;
    test_reset();
    test_basic_add();
    test_overflow();
    test_backpressure();
    test_chain();
    test_saturation();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
